// File: rtl/dm_store_tracer.sv
// rtl/dm_store_tracer.sv - store tracer FIFO snooping the data-memory write port
//
// Purpose:
//   Captures every processor store (trace_en && DM_writeEnable) as a record
//   {seq, addr, data} in an on-chip FIFO and drains the records through a
//   show-ahead valid/ready stream. Stores that find the FIFO full are counted
//   in a saturating drop counter. Their sequence numbers are still consumed,
//   so the consumer can spot the loss as a gap. The processor is never stalled.
//
// Ports:
//   CLOCK_50        system clock, rising edge
//   reset           synchronous active-low reset
//   trace_en        capture enable; when low stores are ignored and seq holds
//   DM_writeEnable  store strobe, one store per high cycle
//   DM_addr         store byte address
//   DM_writeData    store data
//   out_valid       head record available
//   out_ready       consumer accepts the head record this cycle
//   out_seq         head record sequence number (0 when !out_valid)
//   out_addr        head record address (0 when !out_valid)
//   out_data        head record data (0 when !out_valid)
//   count           entries currently held
//   full            count == DEPTH
//   empty           count == 0
//   drop_cnt        stores lost to a full FIFO, saturating at 255
module dm_store_tracer #(
  parameter int N     = 64,
  parameter int DEPTH = 16,
  parameter int SEQW  = 16
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     trace_en,
  input  logic                     DM_writeEnable,
  input  logic [N-1:0]             DM_addr,
  input  logic [N-1:0]             DM_writeData,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SEQW-1:0]          out_seq,
  output logic [N-1:0]             out_addr,
  output logic [N-1:0]             out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = SEQW + 2 * N;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [RW-1:0]   ram [DEPTH];
  logic [AW-1:0]   rdPtr;
  logic [AW-1:0]   wrPtr;
  logic [AW:0]     cnt;
  logic [SEQW-1:0] seq;
  logic [7:0]      dropCnt;
  logic [RW-1:0]   headRec;

  logic storeEv;
  logic popEv;
  logic pushEv;
  logic dropEv;

  assign storeEv = trace_en && DM_writeEnable;
  assign popEv   = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the store.
  assign pushEv  = storeEv && ((cnt != FULL_CNT) || popEv);
  assign dropEv  = storeEv && !pushEv;

  // Record storage is deliberately not reset; pointers and count define validity.
  always_ff @(posedge CLOCK_50) begin
    if (reset && pushEv) begin
      ram[wrPtr] <= {seq, DM_addr, DM_writeData};
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      rdPtr   <= '0;
      wrPtr   <= '0;
      cnt     <= '0;
      seq     <= '0;
      dropCnt <= '0;
    end else begin
      if (pushEv) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (popEv) begin
        rdPtr <= rdPtr + 1'b1;
      end
      if (pushEv && !popEv) begin
        cnt <= cnt + 1'b1;
      end else if (popEv && !pushEv) begin
        cnt <= cnt - 1'b1;
      end
      // Every store event burns a sequence number, dropped or not.
      if (storeEv) begin
        seq <= seq + 1'b1;
      end
      if (dropEv && (dropCnt != 8'hFF)) begin
        dropCnt <= dropCnt + 1'b1;
      end
    end
  end

  assign headRec   = ram[rdPtr];
  assign empty     = (cnt == '0);
  assign full      = (cnt == FULL_CNT);
  assign out_valid = !empty;
  assign count     = cnt;
  assign drop_cnt  = dropCnt;

  // Show-ahead head; fields forced to zero so stale RAM never leaks out.
  assign out_seq  = out_valid ? headRec[RW-1 -: SEQW] : '0;
  assign out_addr = out_valid ? headRec[2*N-1 -: N]   : '0;
  assign out_data = out_valid ? headRec[N-1:0]        : '0;

endmodule

// File: doc/dm_store_tracer.md
Name: dm_store_tracer

Overview:
- Sits directly downstream of the single-cycle processor top, alongside data memory, on the same CLOCK_50 domain.
- Snoops the processor's data-memory write port (DM_writeEnable, DM_addr, DM_writeData).
- Records every store into an on-chip FIFO, tagged with a sequence number.
- Drains records through a valid/ready stream to a host-side consumer (UART bridge or testbench checker).
- Counts stores lost to a full FIFO.

Parameters:
N, 64, data/address width of the snooped DM port
DEPTH, 16, FIFO entries; power of two, >= 2
SEQW, 16, sequence-number width

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
trace_en  in  1  1 = capture stores; 0 = ignore them (not counted, seq frozen)
DM_writeEnable  in  1  store strobe from processor, one store per high cycle
DM_addr  in  N  store byte address
DM_writeData  in  N  store data
out_valid  out  1  head record available
out_ready  in  1  consumer accepts head record this cycle
out_seq  out  SEQW  sequence number of head record
out_addr  out  N  address of head record
out_data  out  N  data of head record
count  out  $clog2(DEPTH)+1  entries currently held
full  out  1  count == DEPTH
empty  out  1  count == 0
drop_cnt  out  8  stores lost because FIFO full; saturates at 255

Behaviour:
- Reset (reset==0 at a rising edge): clears rd_ptr, wr_ptr, count, seq, drop_cnt.
  - After reset: out_valid=0, empty=1, full=0.
  - out_seq/out_addr/out_data read 0.
  - RAM contents are not reset.
- Reset dominates all other inputs in the same cycle.
  - Reset mid-stream discards all held records; nothing is emitted afterwards.
- Store event: trace_en && DM_writeEnable sampled high at a rising edge.
  - Each event consumes one seq value: record tagged with current seq, then seq <= seq+1.
  - seq wraps modulo 2^SEQW.
  - Consumed even when the record is dropped, so the consumer detects loss by seq gaps.
- Pop: out_valid && out_ready at a rising edge. rd_ptr advances.
- Push: store event and (count < DEPTH, or a pop in the same cycle).
  - Writes {seq, DM_addr, DM_writeData} at wr_ptr; wr_ptr advances.
- Full with a simultaneous pop: push accepted, count unchanged, no drop.
- Full with no pop: record dropped, drop_cnt <= min(drop_cnt+1, 255), seq still increments.
- Empty with simultaneous store and out_ready: no bypass.
  - Record appears the next cycle; out_valid is 0 in the current cycle.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.
- Pointers are log2(DEPTH) bits and wrap naturally; full/empty derive from count.
- Head outputs are show-ahead.
  - out_valid = !empty.
  - out_seq/out_addr/out_data = RAM[rd_ptr] when out_valid, else 0.
  - Combinational from registered pointer and RAM.
  - A record is visible exactly one cycle after its push edge.
- Handshake:
  - Head outputs hold stable while out_valid && !out_ready.
  - out_valid never drops without a pop or reset.
  - out_ready while !out_valid is ignored.
- Latency: store edge to out_valid = 1 cycle (empty FIFO). Throughput 1 record/cycle in and out.
- trace_en falling does not flush; held records still drain.
- The block never back-pressures the processor; stores always complete in data memory.

Test Plan:
1. Reset then trace_en=1, three stores (addr 0x08/0x10/0x18, data 0xA/0xB/0xC), out_ready=1.
   - Records seq 0,1,2 appear in order, each 1 cycle after its store.
   - drop_cnt=0; empty=1 afterwards.
2. out_ready=0, DEPTH+3 consecutive stores.
   - full=1 after 16th; drop_cnt=3; seq reaches 19.
   - Draining yields seq 0..15 unchanged, then empty.
3. FIFO full, store and out_ready=1 in the same cycle.
   - Pop seq 0, push accepted at tail; count stays 16, drop_cnt unchanged.
4. Empty FIFO, store with out_ready=1 that cycle.
   - out_valid=0 that cycle; next cycle out_valid=1 with the record; pops on the following edge.
5. Hold out_ready=0 for 5 cycles with 2 records held.
   - out_seq/out_addr/out_data stable, out_valid=1 throughout.
   - trace_en=0 with stores: no pushes, seq frozen.
6. Reset asserted with 5 records held and 200 drops accumulated.
   - Next cycle: count=0, out_valid=0, drop_cnt=0.
   - First subsequent store emits seq 0.
   - Separately, 300 drops saturate drop_cnt at 255.
